// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one fixed-latency FP16 multiplier among NUM_REQ requesters,
// with ID-tagged in-flight tracking and a per-requester result holding register.
module fp16_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [16*NUM_REQ-1:0]  rsp_data,
  output logic                   mul_a_tvalid,
  output logic [31:0]            mul_a_tdata,
  output logic                   mul_b_tvalid,
  output logic [31:0]            mul_b_tdata,
  input  logic                   mul_result_tvalid,
  input  logic [31:0]            mul_result_tdata,
  output logic                   busy,
  output logic                   err_tag
);
  logic [NUM_REQ-1:0] pending, pending_nxt, eligible, cap_vec;
  logic [ID_W-1:0] ptr, gnt_id, issue_id, tag_out_id;
  logic gnt, tag_out_vld, cap, unused_hi;
  logic [MUL_LATENCY-1:0] tag_vld;
  logic [ID_W-1:0] tag_id [MUL_LATENCY];

  assign eligible    = req_valid & ~pending;
  assign tag_out_vld = tag_vld[MUL_LATENCY-1];
  assign tag_out_id  = tag_id[MUL_LATENCY-1];
  assign cap         = tag_out_vld & mul_result_tvalid;
  assign cap_vec     = cap ? NUM_REQ'(1) << tag_out_id : '0;
  assign pending_nxt = (pending | req_ready) & ~(rsp_valid & rsp_ready);
  assign mul_b_tvalid = mul_a_tvalid;
  assign unused_hi   = ^mul_result_tdata[31:16];

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx = 0;
    req_ready = '0;
    gnt_id = '0;
    gnt = 1'b0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(ptr) + o) % NUM_REQ;
      if (eligible[idx] && !gnt) begin
        gnt = 1'b1;
        gnt_id = ID_W'(idx);
        req_ready = NUM_REQ'(1) << idx;
      end
    end
  end

  // issue_id travels with mul_a_tvalid; the tag pipe then adds MUL_LATENCY stages.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= '0;
      pending <= '0;
      busy <= 1'b0;
      err_tag <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      mul_a_tvalid <= 1'b0;
      mul_a_tdata <= '0;
      mul_b_tdata <= '0;
      issue_id <= '0;
      tag_vld <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      mul_a_tvalid <= gnt;
      if (gnt) begin
        mul_a_tdata <= {16'h0, req_a[16*int'(gnt_id) +: 16]};
        mul_b_tdata <= {16'h0, req_b[16*int'(gnt_id) +: 16]};
        issue_id <= gnt_id;
        ptr <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
      end
      tag_vld[0] <= mul_a_tvalid;
      tag_id[0] <= issue_id;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      pending <= pending_nxt;
      busy <= |pending_nxt;
      rsp_valid <= (rsp_valid & ~rsp_ready) | cap_vec;
      if (cap) rsp_data[16*int'(tag_out_id) +: 16] <= mul_result_tdata[15:0];
      if (mul_result_tvalid ^ tag_out_vld) err_tag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed checks of arbitration, tagging, backpressure, error and reset behaviour
// against a latency-3 multiplier stub returning hand-computed FP16 products.
module tb_fp16_mul_arbiter;
  logic aclk, aresetn;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b, rsp_data;
  logic mul_a_tvalid, mul_b_tvalid, mul_result_tvalid, busy, err_tag;
  logic [31:0] mul_a_tdata, mul_b_tdata, mul_result_tdata;
  logic inject, suppress;
  logic [2:0] sv;
  logic [15:0] sa [3];
  logic [15:0] sb [3];
  logic tb_unused;
  int checks = 0;
  int errors = 0;
  logic [3:0] fair_exp [8] = '{4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};

  fp16_mul_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_a_tvalid(mul_a_tvalid), .mul_a_tdata(mul_a_tdata),
    .mul_b_tvalid(mul_b_tvalid), .mul_b_tdata(mul_b_tdata),
    .mul_result_tvalid(mul_result_tvalid), .mul_result_tdata(mul_result_tdata),
    .busy(busy), .err_tag(err_tag)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [15:0] prod(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h4000_4200: return 16'h4600;
      32'h3C00_4400: return 16'h4400;
      32'h4000_4000: return 16'h4400;
      32'h4200_4200: return 16'h4880;
      32'h4400_4000: return 16'h4800;
      32'h3800_4000: return 16'h3C00;
      default:       return 16'hFFFF;
    endcase
  endfunction

  // Multiplier stub: result valid three cycles after input tvalid is sampled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sv <= '0;
      for (int s = 0; s < 3; s++) begin
        sa[s] <= '0;
        sb[s] <= '0;
      end
    end else begin
      sv <= {sv[1:0], mul_a_tvalid & mul_b_tvalid};
      sa[0] <= mul_a_tdata[15:0];
      sb[0] <= mul_b_tdata[15:0];
      for (int s = 1; s < 3; s++) begin
        sa[s] <= sa[s-1];
        sb[s] <= sb[s-1];
      end
    end
  end
  assign mul_result_tvalid = (sv[2] & ~suppress) | inject;
  assign mul_result_tdata = {16'h0, prod(sa[2], sb[2])};
  assign tb_unused = ^{mul_a_tdata[31:16], mul_b_tdata[31:16]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    inject = 1'b0; suppress = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tvalid", mul_a_tvalid, 0);
    chk("rst_err", err_tag, 0);
    @(negedge aclk); aresetn = 1'b1;
    // All four valid, pointer at 0
    @(negedge aclk);
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    req_a = {16'h3800, 16'h4400, 16'h4200, 16'h4000};
    req_b = {16'h4000, 16'h4000, 16'h4200, 16'h4000};
    #1; chk("all_gnt0", req_ready, 4'b0001);
    @(negedge aclk); req_valid = 4'b1110; #1;
    chk("all_gnt1", req_ready, 4'b0010);
    chk("all_tv1", mul_a_tvalid, 1);
    chk("all_a0", mul_a_tdata, 32'h4000);
    @(negedge aclk); req_valid = 4'b1100; #1;
    chk("all_gnt2", req_ready, 4'b0100);
    chk("all_b1", mul_b_tdata, 32'h4200);
    @(negedge aclk); req_valid = 4'b1000; #1;
    chk("all_gnt3", req_ready, 4'b1000);
    chk("all_a2", mul_a_tdata, 32'h4400);
    @(negedge aclk); req_valid = 4'b0000; #1;
    chk("all_tv4", {mul_a_tvalid, mul_b_tvalid}, 2'b11);
    chk("all_a3", mul_a_tdata, 32'h3800);
    @(negedge aclk); #1;
    chk("all_tv5", mul_a_tvalid, 0);
    chk("all_rsp0", {rsp_valid, rsp_data[15:0]}, {4'b0001, 16'h4400});
    @(negedge aclk); #1;
    chk("all_rsp1", {rsp_valid, rsp_data[31:16]}, {4'b0010, 16'h4880});
    @(negedge aclk); #1;
    chk("all_rsp2", {rsp_valid, rsp_data[47:32]}, {4'b0100, 16'h4800});
    @(negedge aclk); #1;
    chk("all_rsp3", {rsp_valid, rsp_data[63:48]}, {4'b1000, 16'h3C00});
    @(negedge aclk); #1;
    chk("all_idle", {busy, err_tag, rsp_valid}, 0);
    // Single op on requester 0
    @(negedge aclk);
    rsp_ready = 4'b0000; req_valid = 4'b0001; req_a[15:0] = 16'h4000; req_b[15:0] = 16'h4200;
    #1; chk("s_gnt", req_ready, 4'b0001);
    chk("s_busy0", busy, 0);
    @(negedge aclk); #1;
    chk("s_tv", {mul_a_tvalid, mul_b_tvalid}, 2'b11);
    chk("s_ab", {mul_a_tdata, mul_b_tdata}, {32'h4000, 32'h4200});
    chk("s_busy1", busy, 1);
    chk("s_blocked", req_ready, 0);
    @(negedge aclk); #1;
    chk("s_tv_off", mul_a_tvalid, 0);
    chk("s_hold", mul_a_tdata, 32'h4000);
    repeat (2) @(negedge aclk);
    #1; chk("s_rsp_early", rsp_valid, 0);
    @(negedge aclk); rsp_ready = 4'b0001; #1;
    chk("s_rsp", {rsp_valid, rsp_data[15:0]}, {4'b0001, 16'h4600});
    chk("s_hs_cycle", {busy, req_ready}, {1'b1, 4'b0000});
    @(negedge aclk); req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4400; #1;
    chk("s_after", {busy, rsp_valid}, 0);
    chk("s_regnt", req_ready, 4'b0001);
    @(negedge aclk); req_valid = 4'b0000; #1;
    chk("s2_busy", busy, 1);
    repeat (3) @(negedge aclk);
    #1; chk("s2_early", rsp_valid, 0);
    @(negedge aclk); #1;
    chk("s2_rsp", {rsp_valid, rsp_data[15:0]}, {4'b0001, 16'h4400});
    @(negedge aclk); rsp_ready = 4'b0000; #1;
    chk("s2_idle", {busy, rsp_valid}, 0);
    // Fairness: req0 and req2 continuously valid
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (i == 0) begin
        req_valid = 4'b0101; rsp_ready = 4'b1111;
        req_a[15:0] = 16'h4000; req_b[15:0] = 16'h4200;
        req_a[47:32] = 16'h4400; req_b[47:32] = 16'h4000;
      end
      #1; chk($sformatf("fair_gnt%0d", i), req_ready, fair_exp[i]);
    end
    chk("fair_data", {rsp_data[47:32], rsp_data[15:0]}, {16'h4800, 16'h4600});
    @(negedge aclk); req_valid = 4'b0000;
    repeat (5) @(negedge aclk);
    #1; chk("fair_idle", busy, 0);
    // Backpressure on requester 1
    @(negedge aclk);
    req_valid = 4'b0010; rsp_ready = 4'b0000; req_a[31:16] = 16'h4200; req_b[31:16] = 16'h4200;
    #1; chk("bp_gnt", req_ready, 4'b0010);
    repeat (4) @(negedge aclk);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk); #1;
      chk($sformatf("bp_hold%0d", i), {rsp_valid, rsp_data[31:16], req_ready}, {4'b0010, 16'h4880, 4'b0000});
    end
    @(negedge aclk); rsp_ready = 4'b0010; #1;
    chk("bp_hs", {rsp_valid, req_ready}, {4'b0010, 4'b0000});
    @(negedge aclk); rsp_ready = 4'b0000; req_a[31:16] = 16'h3C00; req_b[31:16] = 16'h4400; #1;
    chk("bp_regnt", {rsp_valid, req_ready}, {4'b0000, 4'b0010});
    @(negedge aclk); req_valid = 4'b0000; rsp_ready = 4'b1111;
    repeat (4) @(negedge aclk);
    #1; chk("bp_rsp2", {rsp_valid, rsp_data[31:16]}, {4'b0010, 16'h4400});
    @(negedge aclk); #1;
    chk("bp_idle", {busy, err_tag}, 0);
    // Unexpected result with empty tag pipe
    @(negedge aclk); inject = 1'b1;
    @(negedge aclk); inject = 1'b0; #1;
    chk("inj_err", {err_tag, rsp_valid, busy}, {1'b1, 4'b0000, 1'b0});
    @(negedge aclk); #1;
    chk("inj_sticky", err_tag, 1);
    // Reset while two ops are in flight
    @(negedge aclk); req_valid = 4'b0011; #1;
    chk("rr_gnt0", req_ready, 4'b0001);
    @(negedge aclk); req_valid = 4'b0010; #1;
    chk("rr_gnt1", req_ready, 4'b0010);
    @(negedge aclk); req_valid = 4'b0000; aresetn = 1'b0; #1;
    chk("rr_zero", {rsp_valid, busy, err_tag, mul_a_tvalid, mul_b_tvalid, req_ready}, 0);
    chk("rr_tdata", {mul_a_tdata, mul_b_tdata}, 0);
    chk("rr_rdata", rsp_data, 0);
    @(negedge aclk); aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk); #1;
      chk($sformatf("rr_stale%0d", i), {rsp_valid, err_tag, busy}, 0);
    end
    @(negedge aclk);
    req_valid = 4'b1001; req_a[15:0] = 16'h4000; req_b[15:0] = 16'h4200;
    #1; chk("rr_ptr0", req_ready, 4'b0001);
    @(negedge aclk); req_valid = 4'b0000;
    repeat (4) @(negedge aclk);
    #1; chk("rr_new", {rsp_valid, rsp_data[15:0], err_tag}, {4'b0001, 16'h4600, 1'b0});
    // Suppressed result: error flagged, requester stays pending
    @(negedge aclk);
    req_valid = 4'b0100; suppress = 1'b1; req_a[47:32] = 16'h4400; req_b[47:32] = 16'h4000;
    #1; chk("sup_gnt", req_ready, 4'b0100);
    @(negedge aclk); req_valid = 4'b0000;
    repeat (4) @(negedge aclk);
    #1; chk("sup_err", {err_tag, rsp_valid, busy}, {1'b1, 4'b0000, 1'b1});
    @(negedge aclk); suppress = 1'b0; req_valid = 4'b0100; #1;
    chk("sup_stall", {req_ready, busy}, {4'b0000, 1'b1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
